instr_fetch_queue: RTL



---
 rtl/instr_fetch_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Circular-buffer queue of {PC, instruction} pairs between fetch
//            and decode. Valid/ready on both sides, flush discards all
//            entries in flight, no bypass path from input to output.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PCW   = 64,
    parameter int IW    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PCW-1:0]           in_pc,
    input  logic [IW-1:0]            in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PCW-1:0]           out_pc,
    output logic [IW-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage and bookkeeping
    logic [PCW-1:0] pc_q    [DEPTH];
    logic [IW-1:0]  instr_q [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic push;
    logic pop;

    // Handshake outputs: in_ready depends only on occupancy, flush masks valid
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0) & ~flush;
    assign out_pc    = pc_q[rptr_q];
    assign out_instr = instr_q[rptr_q];
    assign count     = count_q;

    // A flushed cycle neither accepts nor delivers an entry
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    // Next-state pointers and occupancy; flush returns everything to zero
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth makes the natural pointer overflow the wrap
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State update; reset also scrubs storage so the output reads zero
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) begin
                pc_q[wptr_q]    <= in_pc;
                instr_q[wptr_q] <= in_instr;
            end
        end
    end

endmodule
`default_nettype wire
